// File: rtl/tmm_seq_ctrl.sv
// Sequencer for a 3D tensor-matrix multiply: walks b/i/j/k, emits operand addresses and MAC controls.
// Optional TMM_CTRL_PERF_EN adds a saturating 32-bit stall counter output (stall_cnt).
module tmm_seq_ctrl #(
    parameter int DIM_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_b,
    input  logic [DIM_W-1:0]  cfg_n,
    input  logic [DIM_W-1:0]  cfg_m,
    input  logic [DIM_W-1:0]  cfg_k,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_clear,
    output logic              mac_last,
    output logic [ADDR_W-1:0] c_addr,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef TMM_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic [DIM_W-1:0]    dim_b_q, dim_b_d;
    logic [DIM_W-1:0]    dim_n_q, dim_n_d;
    logic [DIM_W-1:0]    dim_m_q, dim_m_d;
    logic [DIM_W-1:0]    dim_k_q, dim_k_d;

    logic [DIM_W-1:0]    b_idx_q, b_idx_d;
    logic [DIM_W-1:0]    i_idx_q, i_idx_d;
    logic [DIM_W-1:0]    j_idx_q, j_idx_d;
    logic [DIM_W-1:0]    k_idx_q, k_idx_d;

    logic [ADDR_W-1:0]   a_row_base_q, a_row_base_d;
    logic [ADDR_W-1:0]   a_addr_q, a_addr_d;
    logic [ADDR_W-1:0]   b_addr_q, b_addr_d;
    logic [ADDR_W-1:0]   c_addr_q, c_addr_d;

    logic                op_valid_q, op_valid_d;
    logic                mac_clear_q, mac_clear_d;
    logic                mac_last_q, mac_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

`ifdef TMM_CTRL_PERF_EN
    logic [31:0]         stall_cnt_q, stall_cnt_d;
`endif

    logic                last_k, last_j, last_i, last_b;
    logic                cfg_zero;
    logic [DIM_W-1:0]    k_inc;

    assign last_k   = (k_idx_q == dim_k_q - DIM_W'(1));
    assign last_j   = (j_idx_q == dim_m_q - DIM_W'(1));
    assign last_i   = (i_idx_q == dim_n_q - DIM_W'(1));
    assign last_b   = (b_idx_q == dim_b_q - DIM_W'(1));
    assign k_inc    = k_idx_q + DIM_W'(1);
    assign cfg_zero = (cfg_b == '0) || (cfg_n == '0) || (cfg_m == '0) || (cfg_k == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dim_b_q      <= '0;
            dim_n_q      <= '0;
            dim_m_q      <= '0;
            dim_k_q      <= '0;
            b_idx_q      <= '0;
            i_idx_q      <= '0;
            j_idx_q      <= '0;
            k_idx_q      <= '0;
            a_row_base_q <= '0;
            a_addr_q     <= '0;
            b_addr_q     <= '0;
            c_addr_q     <= '0;
            op_valid_q   <= 1'b0;
            mac_clear_q  <= 1'b0;
            mac_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef TMM_CTRL_PERF_EN
            stall_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            dim_b_q      <= dim_b_d;
            dim_n_q      <= dim_n_d;
            dim_m_q      <= dim_m_d;
            dim_k_q      <= dim_k_d;
            b_idx_q      <= b_idx_d;
            i_idx_q      <= i_idx_d;
            j_idx_q      <= j_idx_d;
            k_idx_q      <= k_idx_d;
            a_row_base_q <= a_row_base_d;
            a_addr_q     <= a_addr_d;
            b_addr_q     <= b_addr_d;
            c_addr_q     <= c_addr_d;
            op_valid_q   <= op_valid_d;
            mac_clear_q  <= mac_clear_d;
            mac_last_q   <= mac_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef TMM_CTRL_PERF_EN
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        dim_b_d      = dim_b_q;
        dim_n_d      = dim_n_q;
        dim_m_d      = dim_m_q;
        dim_k_d      = dim_k_q;
        b_idx_d      = b_idx_q;
        i_idx_d      = i_idx_q;
        j_idx_d      = j_idx_q;
        k_idx_d      = k_idx_q;
        a_row_base_d = a_row_base_q;
        a_addr_d     = a_addr_q;
        b_addr_d     = b_addr_q;
        c_addr_d     = c_addr_q;
        op_valid_d   = op_valid_q;
        mac_clear_d  = mac_clear_q;
        mac_last_d   = mac_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
`ifdef TMM_CTRL_PERF_EN
        stall_cnt_d  = stall_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dim_b_d      = cfg_b;
                    dim_n_d      = cfg_n;
                    dim_m_d      = cfg_m;
                    dim_k_d      = cfg_k;
                    b_idx_d      = '0;
                    i_idx_d      = '0;
                    j_idx_d      = '0;
                    k_idx_d      = '0;
                    a_row_base_d = '0;
                    a_addr_d     = '0;
                    b_addr_d     = '0;
                    c_addr_d     = '0;
`ifdef TMM_CTRL_PERF_EN
                    stall_cnt_d  = '0;
`endif
                    if (cfg_zero) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        err_d       = 1'b1;
                        op_valid_d  = 1'b0;
                        busy_d      = 1'b0;
                        mac_clear_d = 1'b0;
                        mac_last_d  = 1'b0;
                    end else begin
                        state_d     = S_RUN;
                        op_valid_d  = 1'b1;
                        busy_d      = 1'b1;
                        mac_clear_d = 1'b1;
                        mac_last_d  = (cfg_k == DIM_W'(1));
                    end
                end
            end

            S_RUN: begin
`ifdef TMM_CTRL_PERF_EN
                if (op_valid_q && !op_ready && (stall_cnt_q != '1))
                    stall_cnt_d = stall_cnt_q + 32'd1;
`endif
                if (op_valid_q && op_ready) begin
                    if (!last_k) begin
                        k_idx_d     = k_inc;
                        a_addr_d    = a_addr_q + ADDR_W'(1);
                        b_addr_d    = b_addr_q + ADDR_W'(dim_m_q);
                        mac_clear_d = 1'b0;
                        mac_last_d  = (k_inc == dim_k_q - DIM_W'(1));
                    end else begin
                        // Row index b*N+i advances by one whenever j wraps, so the C
                        // address simply increments at the end of every dot product.
                        k_idx_d     = '0;
                        mac_clear_d = 1'b1;
                        mac_last_d  = (dim_k_q == DIM_W'(1));
                        c_addr_d    = c_addr_q + ADDR_W'(1);
                        if (!last_j) begin
                            j_idx_d  = j_idx_q + DIM_W'(1);
                            a_addr_d = a_row_base_q;
                            b_addr_d = ADDR_W'(j_idx_q + DIM_W'(1));
                        end else begin
                            j_idx_d      = '0;
                            b_addr_d     = '0;
                            a_row_base_d = a_row_base_q + ADDR_W'(dim_k_q);
                            a_addr_d     = a_row_base_q + ADDR_W'(dim_k_q);
                            if (!last_i) begin
                                i_idx_d = i_idx_q + DIM_W'(1);
                            end else begin
                                i_idx_d = '0;
                                if (!last_b) begin
                                    b_idx_d = b_idx_q + DIM_W'(1);
                                end else begin
                                    state_d     = S_DONE;
                                    op_valid_d  = 1'b0;
                                    busy_d      = 1'b0;
                                    done_d      = 1'b1;
                                    mac_clear_d = 1'b0;
                                    mac_last_d  = 1'b0;
                                end
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d    = S_IDLE;
                op_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    assign op_valid  = op_valid_q;
    assign a_addr    = a_addr_q;
    assign b_addr    = b_addr_q;
    assign c_addr    = c_addr_q;
    assign mac_clear = mac_clear_q;
    assign mac_last  = mac_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
`ifdef TMM_CTRL_PERF_EN
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/tmm_seq_ctrl.md
Name: tmm_seq_ctrl

Overview:
Sequencer for the 3D tensor-matrix multiply datapath, computing C[b][i][j] = sum over k of A[b][i][k]*B[k][j].
- Walks the b/i/j/k index space and emits one operand-fetch address pair per MAC operation.
- Drives MAC accumulator control: clear on first term, last on final term.
- Supplies the result write address for each completed dot product.
- Sits between the host/config logic and the MAC datapath plus its operand/result memories.

Parameters:
DIM_W, 8, width of each dimension register (B, N, M, K); legal dimension range is 1..2^DIM_W-1.
ADDR_W, 16, width of the A, B and C address outputs; all address arithmetic wraps mod 2^ADDR_W.

Ports:
clk  in  1  clock; single clock domain
rst_n  in  1  asynchronous active-low reset
start  in  1  start pulse; honoured only in IDLE
cfg_b  in  DIM_W  batch count B
cfg_n  in  DIM_W  rows N
cfg_m  in  DIM_W  columns M
cfg_k  in  DIM_W  reduction length K
op_valid  out  1  operand addresses and MAC controls valid
op_ready  in  1  datapath accepts the current op
a_addr  out  ADDR_W  A address = (b*N+i)*K+k
b_addr  out  ADDR_W  B address = k*M+j
mac_clear  out  1  first term of a dot product (k==0)
mac_last  out  1  last term of a dot product (k==K-1)
c_addr  out  ADDR_W  C address = (b*N+i)*M+j; meaningful when mac_last=1
busy  out  1  high while in RUN
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done when any dimension is 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output 0; index and base registers 0. A reset mid-run aborts immediately; no further ops are issued.
- States:
  - IDLE: on start=1, latch cfg_*. If any latched dimension is 0, go to DONE with err=1. Otherwise go to RUN with b=i=j=k=0.
  - RUN: op_valid=1 and busy=1 every cycle. Outputs reflect current indices and are registered.
  - RUN handshake: when op_valid&&op_ready, advance indices. k is innermost, then j, then i, then b.
  - RUN exit: on the handshake of the final op (b=B-1, i=N-1, j=M-1, k=K-1), go to DONE; op_valid drops the next cycle.
  - DONE: done=1 for exactly one cycle; busy=0; op_valid=0. Always go to IDLE next.
- Latency: start sampled at edge t gives op_valid=1 with the first op in cycle t+1. done is asserted the cycle after the final handshake.
- Stall: while op_valid=1 and op_ready=0, all op outputs hold stable. No handshake is required in DONE or IDLE.
- Total ops per run = B*N*M*K. mac_clear and mac_last are each asserted B*N*M times. With K=1 both are asserted on every op.
- Address generation is incremental; no multipliers. Keep running row bases for A (k stride 1, row stride K) and C (row stride M). Keep a B base of k*M plus j. All additions wrap at ADDR_W bits.
- Config inputs are ignored outside IDLE. start is ignored in RUN and DONE.
- A start arriving in the same cycle the FSM returns to IDLE is not accepted; it must arrive while the state is IDLE.

Optional Feature:
TMM_CTRL_PERF_EN
- Defined: adds output stall_cnt (32 bits). It is cleared on an accepted start and increments each RUN cycle with op_valid=1 and op_ready=0. It saturates at 2^32-1, holds after done, and resets to 0 on rst_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- B=1,N=2,M=2,K=3, op_ready=1 -> 12 consecutive ops; a_addr 0,1,2,0,1,2,3,4,5,3,4,5; b_addr 0,2,4,1,3,5,0,2,4,1,3,5; mac_last on ops 3,6,9,12 with c_addr 0,1,2,3; done 1 cycle after op 12.
- B=2,N=1,M=1,K=1 -> 2 ops, each with mac_clear=mac_last=1; c_addr 0 then 1; a_addr 0 then 1.
- Same config as test 1, op_ready toggling 1010… -> outputs stable during stalls; identical address sequence; 23 op_valid cycles. With TMM_CTRL_PERF_EN, stall_cnt=11.
- cfg_k=0 with start -> no op_valid; done=err=1 for one cycle, 1 cycle after start.
- rst_n pulled low at op 5 of test 1 -> all outputs 0 asynchronously. A new start after release restarts at a_addr=0.
- start held high during RUN -> ignored; exactly one run of 12 ops.
